// File: rtl/grey_pointer_receiver.sv
// Receive side of a Grey-coded pointer crossing: synchronize, decode,
// report per-cycle advance, and flag illegal multi-bit code changes.
module grey_pointer_receiver #(
  parameter int WIDTH             = 4,
  parameter int STAGES            = 2,
  parameter bit CHECK_SINGLE_STEP = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] grey_in,
  input  logic             error_clear,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] delta,
  output logic             advance,
  output logic             error
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] sync_bin;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= grey_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // Bit i of the binary value is the XOR of all Grey bits at or above i.
  always_comb begin
    sync_bin = '0;
    for (int i = 0; i < WIDTH; i++) sync_bin[i] = ^(sync_out >> i);
  end

  assign diff      = sync_bin - binary;
  assign multi_bit = $countones(sync_out ^ grey) > 1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grey    <= '0;
      binary  <= '0;
      delta   <= '0;
      advance <= 1'b0;
    end else begin
      grey    <= sync_out;
      binary  <= sync_bin;
      delta   <= diff;
      advance <= |diff;
    end
  end

  generate
    if (CHECK_SINGLE_STEP) begin : g_mon
      // A new violation beats a simultaneous clear.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          error <= 1'b0;
        else if (multi_bit)   error <= 1'b1;
        else if (error_clear) error <= 1'b0;
      end
    end else begin : g_no_mon
      assign error = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_grey_pointer_receiver.sv
// Randomized bench for grey_pointer_receiver against a queue-based
// model of the sampling delay plus literal checks of key scenarios.
module tb_grey_pointer_receiver;

  localparam int W = 4;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         resetn;
  logic [W-1:0] grey_in;
  logic         error_clear;
  logic [W-1:0] binary, grey, delta;
  logic         advance, error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] e_grey, e_bin, e_delta;
  logic         e_adv, e_err;

  grey_pointer_receiver #(
    .WIDTH(W), .STAGES(S), .CHECK_SINGLE_STEP(1'b1)
  ) dut (
    .clock(clock), .resetn(resetn), .grey_in(grey_in),
    .error_clear(error_clear), .binary(binary), .grey(grey),
    .delta(delta), .advance(advance), .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] to_grey(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Decode by searching for the count whose Grey code matches.
  function automatic logic [W-1:0] dec(input logic [W-1:0] g);
    logic [W-1:0] v;
    for (int i = 0; i < (1 << W); i++) begin
      v = W'(i);
      if (to_grey(v) == g) return v;
    end
    return '0;
  endfunction

  task automatic model_reset();
    q.delete();
    e_grey = '0; e_bin = '0; e_delta = '0;
    e_adv = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] g_new, b_new;
    if (!resetn) begin
      model_reset();
      return;
    end
    g_new = (q.size() == S) ? q.pop_front() : '0;
    q.push_back(grey_in);
    b_new   = dec(g_new);
    e_delta = b_new - e_bin;
    e_adv   = (b_new != e_bin);
    if ($countones(g_new ^ e_grey) > 1) e_err = 1'b1;
    else if (error_clear) e_err = 1'b0;
    e_grey = g_new;
    e_bin  = b_new;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("grey", grey, e_grey);
    chk("binary", binary, e_bin);
    chk("delta", delta, e_delta);
    chk("advance", W'(advance), W'(e_adv));
    chk("error", W'(error), W'(e_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  task automatic pin(input logic [W-1:0] g, input logic [W-1:0] b,
                     input logic [W-1:0] d, input logic a,
                     input logic e);
    chk("pin_grey", grey, g);
    chk("pin_binary", binary, b);
    chk("pin_delta", delta, d);
    chk("pin_advance", W'(advance), W'(a));
    chk("pin_error", W'(error), W'(e));
  endtask

  task automatic drive(input logic [W-1:0] g, input int n);
    grey_in = g;
    repeat (n) step();
  endtask

  task automatic clear_pulse();
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
  endtask

  logic [W-1:0] cnt;

  initial begin
    resetn = 1'b0;
    grey_in = 4'b1010;
    error_clear = 1'b0;
    model_reset();
    repeat (2) step();
    pin(4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);

    resetn = 1'b1;
    drive(4'b1010, 3);
    pin(4'b1010, 4'd12, 4'd12, 1'b1, 1'b1);

    drive(4'b1010, 1);
    clear_pulse();
    pin(4'b1010, 4'd12, 4'd0, 1'b0, 1'b0);

    drive(4'b0000, 4);
    clear_pulse();
    drive(4'b0001, 1);
    drive(4'b0011, 1);
    drive(4'b0010, 1);
    drive(4'b0110, 1);
    drive(4'b0110, 2);
    pin(4'b0110, 4'd4, 4'd1, 1'b1, 1'b0);
    drive(4'b0110, 1);
    pin(4'b0110, 4'd4, 4'd0, 1'b0, 1'b0);

    drive(4'b1001, 4);
    clear_pulse();
    drive(4'b1000, 1);
    drive(4'b0000, 1);
    drive(4'b0000, 2);
    pin(4'b0000, 4'd0, 4'd1, 1'b1, 1'b0);

    drive(4'b0000, 3);
    drive(4'b0011, 3);
    pin(4'b0011, 4'd2, 4'd2, 1'b1, 1'b1);
    drive(4'b0011, 3);
    pin(4'b0011, 4'd2, 4'd0, 1'b0, 1'b1);

    clear_pulse();
    pin(4'b0011, 4'd2, 4'd0, 1'b0, 1'b0);
    drive(4'b0000, 4);
    clear_pulse();
    drive(4'b0101, 2);
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    pin(4'b0101, 4'd6, 4'd6, 1'b1, 1'b1);

    drive(4'b0000, 4);
    clear_pulse();
    for (int i = 1; i <= 7; i++) drive(to_grey(W'(i)), 1);
    drive(4'b0100, 2);
    pin(4'b0100, 4'd7, 4'd1, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1 pin(4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
    model_reset();
    step();
    resetn = 1'b1;
    drive(4'b0100, 3);
    pin(4'b0100, 4'd7, 4'd7, 1'b1, 1'b0);

    cnt = 4'd7;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 15))
        0:       cnt = W'($urandom);
        1, 2, 3: cnt = cnt;
        default: cnt = cnt + 1'b1;
      endcase
      grey_in = to_grey(cnt);
      error_clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 resetn = 1'b0;
        #1 pin(4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        step();
        resetn = 1'b1;
      end else begin
        step();
      end
    end
    error_clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
